// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and the per-edge action decode for the pipeline stage register.
// An all-zero payload is the NOP encoding for every stage boundary.
package pipe_stage_reg_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam int   STALL_W_DEF = 6;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    // First matching rule wins: flush, then bubble, then hold, else advance.
    function automatic stage_act_e decode_act(input logic flush, input logic up, input logic dn);
        if (flush)
            return ACT_FLUSH;
        else if (up && !dn)
            return ACT_BUBBLE;
        else if (up && dn)
            return ACT_HOLD;
        else
            return ACT_ADVANCE;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear that has priority over increment.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE)
            count_reg <= '0;
        else if (clr)
            count_reg <= '0;
        else if (inc && (count_reg != {CNT_W{1'b1}}))
            count_reg <= count_reg + CNT_W'(1);
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: LANES payload slots with valid, stall/flush
// handling and saturating hold/bubble/flush performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int DW      = 114,
    parameter int STALL_W = STALL_W_DEF,
    parameter int STAGE   = 2,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                cnt_clr,
    input  logic [LANES-1:0]    in_valid,
    input  logic [LANES*DW-1:0] in_data,
    output logic [LANES-1:0]    out_valid,
    output logic [LANES*DW-1:0] out_data,
    output logic [CNT_W-1:0]    hold_cnt,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    if (STAGE >= STALL_W || STAGE < 0 || LANES <= 0) begin : g_param_err
        $error("pipe_stage_reg: illegal STAGE/LANES parameters");
    end

    logic       up;
    logic       dn;
    logic       unused_stall;
    stage_act_e act;

    assign up           = stall[STAGE];
    assign unused_stall = ^stall;

    // The last stage has no downstream stall bit, so it can only bubble, never hold.
    if (STAGE < STALL_W - 1) begin : g_dn
        assign dn = stall[STAGE+1];
    end else begin : g_dn_last
        assign dn = 1'b0;
    end

    always_comb begin
        act = decode_act(flush, up, dn);
    end

    logic [LANES-1:0] valid_reg;
    logic [LANES-1:0] valid_next;
    logic [DW-1:0]    data_reg  [LANES];
    logic [DW-1:0]    data_next [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        always_comb begin
            valid_next[gi] = valid_reg[gi];
            data_next[gi]  = data_reg[gi];
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    valid_next[gi] = 1'b0;
                    data_next[gi]  = '0;
                end
                ACT_ADVANCE: begin
                    valid_next[gi] = in_valid[gi];
                    data_next[gi]  = in_data[gi*DW +: DW];
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (rst == RST_ENABLE) begin
                valid_reg[gi] <= 1'b0;
                data_reg[gi]  <= '0;
            end else begin
                valid_reg[gi] <= valid_next[gi];
                data_reg[gi]  <= data_next[gi];
            end
        end

        assign out_data[gi*DW +: DW] = data_reg[gi];
    end

    assign out_valid = valid_reg;

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (act == ACT_HOLD),
        .count (hold_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (act == ACT_BUBBLE),
        .count (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (act == ACT_FLUSH),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a two-lane middle-stage instance driven from a vector table, plus a
// single-lane last-stage instance and hand sequences for reset, saturation and hold.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // dut0: LANES=2, DW=16, STAGE=2, CNT_W=4
    logic [5:0]  stall0 = '0;
    logic        flush0 = 1'b0;
    logic        clr0 = 1'b0;
    logic [1:0]  iv0 = '0;
    logic [31:0] id0 = '0;
    logic [1:0]  ov0;
    logic [31:0] od0;
    logic [3:0]  hc0, bc0, fc0;

    // dut1: LANES=1, DW=8, STAGE=5 (last), CNT_W=4
    logic [5:0]  stall1 = '0;
    logic        iv1 = 1'b0;
    logic [7:0]  id1 = '0;
    logic        ov1;
    logic [7:0]  od1;
    logic [3:0]  hc1, bc1, fc1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.LANES(2), .DW(16), .STALL_W(6), .STAGE(2), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .stall(stall0), .flush(flush0), .cnt_clr(clr0),
        .in_valid(iv0), .in_data(id0), .out_valid(ov0), .out_data(od0),
        .hold_cnt(hc0), .bubble_cnt(bc0), .flush_cnt(fc0)
    );

    pipe_stage_reg #(.LANES(1), .DW(8), .STALL_W(6), .STAGE(5), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .stall(stall1), .flush(1'b0), .cnt_clr(1'b0),
        .in_valid(iv1), .in_data(id1), .out_valid(ov1), .out_data(od1),
        .hold_cnt(hc1), .bubble_cnt(bc1), .flush_cnt(fc1)
    );

    // up=0 with dn=1 must never come from the stall controller
    always @(posedge clk) begin
        if (rst)
            assert (!(stall0[2] == 1'b0 && stall0[3] == 1'b1))
                else $error("illegal stall combination up=0 dn=1");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        clr;
        logic [1:0]  iv;
        logic [31:0] id;
        logic [1:0]  ev;
        logic [31:0] ed;
        logic [3:0]  eh;
        logic [3:0]  eb;
        logic [3:0]  ef;
    } vec_t;

    function automatic vec_t mk(logic [5:0] st, logic fl, logic cl, logic [1:0] iv,
                                logic [31:0] id, logic [1:0] ev, logic [31:0] ed,
                                logic [3:0] eh, logic [3:0] eb, logic [3:0] ef);
        vec_t v;
        v.stall = st; v.flush = fl; v.clr = cl; v.iv = iv; v.id = id;
        v.ev = ev; v.ed = ed; v.eh = eh; v.eb = eb; v.ef = ef;
        return v;
    endfunction

    task automatic drive0(input logic [5:0] st, input logic fl, input logic cl,
                          input logic [1:0] iv, input logic [31:0] id);
        @(negedge clk);
        stall0 = st; flush0 = fl; clr0 = cl; iv0 = iv; id0 = id;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = mk(6'b000000, 0, 0, 2'b11, 32'h0002_0001, 2'b11, 32'h0002_0001, 0, 0, 0);
        vecs[1]  = mk(6'b000111, 0, 0, 2'b11, 32'h0003_0004, 2'b00, 32'h0,         0, 1, 0);
        vecs[2]  = mk(6'b000000, 0, 0, 2'b01, 32'h1234_0ABC, 2'b01, 32'h1234_0ABC, 0, 1, 0);
        vecs[3]  = mk(6'b001111, 0, 0, 2'b11, 32'hFFFF_FFFF, 2'b01, 32'h1234_0ABC, 1, 1, 0);
        vecs[4]  = mk(6'b001111, 0, 0, 2'b11, 32'hFFFF_FFFF, 2'b01, 32'h1234_0ABC, 2, 1, 0);
        vecs[5]  = mk(6'b001111, 0, 0, 2'b11, 32'hFFFF_FFFF, 2'b01, 32'h1234_0ABC, 3, 1, 0);
        vecs[6]  = mk(6'b000000, 0, 0, 2'b10, 32'h5555_6666, 2'b10, 32'h5555_6666, 3, 1, 0);
        vecs[7]  = mk(6'b001111, 1, 0, 2'b11, 32'h7777_8888, 2'b00, 32'h0,         3, 1, 1);
        vecs[8]  = mk(6'b000011, 0, 0, 2'b11, 32'h0101_0202, 2'b11, 32'h0101_0202, 3, 1, 1);
        vecs[9]  = mk(6'b000111, 1, 1, 2'b11, 32'h0909_0909, 2'b00, 32'h0,         0, 0, 0);
        vecs[10] = mk(6'b001111, 0, 0, 2'b11, 32'h0A0A_0A0A, 2'b00, 32'h0,         1, 0, 0);
        vecs[11] = mk(6'b000000, 1, 0, 2'b11, 32'h0B0B_0B0B, 2'b00, 32'h0,         1, 0, 1);
        vecs[12] = mk(6'b001111, 0, 1, 2'b11, 32'h0C0C_0C0C, 2'b00, 32'h0,         0, 0, 0);

        // reset state while rst is held low
        #12;
        check("reset_valid", 64'(ov0), 64'h0);
        check("reset_data", 64'(od0), 64'h0);
        check("reset_cnts", 64'({hc0, bc0, fc0}), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive0(vecs[i].stall, vecs[i].flush, vecs[i].clr, vecs[i].iv, vecs[i].id);
            check($sformatf("vec%0d_valid", i), 64'(ov0), 64'(vecs[i].ev));
            check($sformatf("vec%0d_data", i), 64'(od0), 64'(vecs[i].ed));
            check($sformatf("vec%0d_hold", i), 64'(hc0), 64'(vecs[i].eh));
            check($sformatf("vec%0d_bubble", i), 64'(bc0), 64'(vecs[i].eb));
            check($sformatf("vec%0d_flush", i), 64'(fc0), 64'(vecs[i].ef));
            $display("[TB] vec %0d stall=%b flush=%b clr=%b -> valid=%b data=%h h=%0d b=%0d f=%0d",
                     i, vecs[i].stall, vecs[i].flush, vecs[i].clr, ov0, od0, hc0, bc0, fc0);
        end

        // bubble counter saturation at 15
        for (int i = 0; i < 20; i++) begin
            drive0(6'b000111, 0, 0, 2'b11, 32'hDEAD_BEEF);
            check($sformatf("sat%0d_bubble", i), 64'(bc0), 64'((i + 1 > 15) ? 15 : i + 1));
            $display("[TB] sat cycle %0d bubble_cnt=%0d", i, bc0);
        end
        check("sat_hold", 64'(hc0), 64'h0);

        // last stage: stall[STAGE]=1 always bubbles, never holds
        @(negedge clk);
        stall0 = '0; iv0 = '0;
        stall1 = 6'b000000; iv1 = 1'b1; id1 = 8'h5A;
        @(posedge clk); #1;
        check("last_adv_data", 64'(od1), 64'h5A);
        check("last_adv_valid", 64'(ov1), 64'h1);
        @(negedge clk);
        stall1 = 6'b100000; id1 = 8'h33;
        @(posedge clk); #1;
        check("last_bub_data", 64'(od1), 64'h0);
        check("last_bub_cnt", 64'(bc1), 64'h1);
        @(negedge clk);
        stall1 = 6'b111111;
        @(posedge clk); #1;
        check("last_all_valid", 64'(ov1), 64'h0);
        check("last_all_bub", 64'(bc1), 64'h2);
        check("last_all_hold", 64'(hc1), 64'h0);
        $display("[TB] last stage bubble_cnt=%0d hold_cnt=%0d", bc1, hc1);
        @(negedge clk);
        stall1 = '0;

        // asynchronous reset in the middle of a hold
        drive0(6'b000000, 0, 1, 2'b11, 32'hABCD_1234);
        drive0(6'b001111, 0, 0, 2'b00, 32'h0);
        check("pre_rst_data", 64'(od0), 64'hABCD_1234);
        check("pre_rst_hold", 64'(hc0), 64'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(ov0), 64'h0);
        check("async_rst_data", 64'(od0), 64'h0);
        check("async_rst_cnts", 64'({hc0, bc0, fc0}), 64'h0);
        $display("[TB] async reset mid-hold -> valid=%b data=%h", ov0, od0);
        @(negedge clk);
        rst = 1'b1;
        drive0(6'b000000, 0, 0, 2'b10, 32'h4321_8765);
        check("post_rst_valid", 64'(ov0), 64'h2);
        check("post_rst_data", 64'(od0), 64'h4321_8765);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
